// File: rtl/steuerung_generisch.sv
// Multi-cycle control FSM for the Hans core: fetch, parametrised decode, ALU, write-back,
// instruction-boundary interrupt entry, halt, and memory-handshake timeout into a terminal bus error.
module steuerung_generisch #(
  parameter int DECODE_ZYKLEN  = 2,
  parameter int TIMEOUT_BREITE = 8,
  parameter int TIMEOUT_ZYKLEN = 200
) (
  input  logic Clock,
  input  logic Reset,
  input  logic BefehlGeladen,
  input  logic ALUFertig,
  input  logic DatenGeladen,
  input  logic DatenGespeichert,
  input  logic LoadBefehl,
  input  logic StoreBefehl,
  input  logic JALBefehl,
  input  logic UnbedingterSprungBefehl,
  input  logic BedingterSprungBefehl,
  input  logic Bedingung,
  input  logic Interrupt,
  input  logic InterruptFreigabe,
  input  logic Halt,
  output logic LoadBefehlSignal,
  output logic DekodierSignal,
  output logic ALUStartSignal,
  output logic RegisterSchreibSignal,
  output logic LoadDatenSignal,
  output logic StoreDatenSignal,
  output logic PCSignal,
  output logic PCSprungSignal,
  output logic InterruptSignal,
  output logic Angehalten,
  output logic BusFehler
);

  typedef enum logic [3:0] {
    START, FETCH, DECODE, ALU, WB_JUMP, WB_STORE, WB_LOAD, WB_DEFAULT, INTERRUPT, HALT, FEHLER
  } zustandT;

  localparam logic [3:0] dekodierLetzter = 4'(DECODE_ZYKLEN - 1);
  localparam bit timeoutAktiv = (TIMEOUT_ZYKLEN != 0);
  localparam logic [TIMEOUT_BREITE-1:0] warteGrenze =
    TIMEOUT_BREITE'(timeoutAktiv ? TIMEOUT_ZYKLEN - 1 : 0);
  localparam logic [TIMEOUT_BREITE-1:0] warteMax = '1;

  // Output vector bit positions
  localparam int bLoadBefehl = 9;
  localparam int bDekodier   = 8;
  localparam int bAluStart   = 7;
  localparam int bRegSchreib = 6;
  localparam int bLoadDaten  = 5;
  localparam int bStoreDaten = 4;
  localparam int bPc         = 3;
  localparam int bInterrupt  = 2;
  localparam int bAngehalten = 1;
  localparam int bBusFehler  = 0;

  zustandT zustand;
  zustandT zustandNext;
  zustandT grenzZiel;
  logic [3:0] dekodierZaehler;
  logic [TIMEOUT_BREITE-1:0] warteZaehler;
  logic [9:0] ausgabe;
  logic [9:0] ausgabeNext;
  logic timeoutJetzt;
  logic irqAktiv;
  logic wartet;

  assign irqAktiv     = Interrupt && InterruptFreigabe;
  assign timeoutJetzt = timeoutAktiv && (warteZaehler == warteGrenze);
  assign wartet       = (zustand == FETCH) || (zustand == WB_STORE) || (zustand == WB_LOAD);
  assign grenzZiel    = irqAktiv ? INTERRUPT : (Halt ? HALT : FETCH);

  always_comb begin
    zustandNext = zustand;
    case (zustand)
      START:      zustandNext = FETCH;
      FETCH: begin
        if (BefehlGeladen)     zustandNext = DECODE;
        else if (timeoutJetzt) zustandNext = FEHLER;
      end
      DECODE: begin
        if (dekodierZaehler == dekodierLetzter) zustandNext = ALU;
      end
      ALU: begin
        if (ALUFertig) begin
          if (UnbedingterSprungBefehl || BedingterSprungBefehl) zustandNext = WB_JUMP;
          else if (StoreBefehl)                                 zustandNext = WB_STORE;
          else if (LoadBefehl)                                  zustandNext = WB_LOAD;
          else                                                  zustandNext = WB_DEFAULT;
        end
      end
      WB_JUMP:    zustandNext = grenzZiel;
      WB_STORE: begin
        if (DatenGespeichert)  zustandNext = grenzZiel;
        else if (timeoutJetzt) zustandNext = FEHLER;
      end
      WB_LOAD: begin
        if (DatenGeladen)      zustandNext = WB_DEFAULT;
        else if (timeoutJetzt) zustandNext = FEHLER;
      end
      WB_DEFAULT: zustandNext = grenzZiel;
      INTERRUPT:  zustandNext = FETCH;
      HALT: begin
        if (irqAktiv)  zustandNext = INTERRUPT;
        else if (!Halt) zustandNext = FETCH;
      end
      FEHLER:     zustandNext = FEHLER;
      default:    zustandNext = START;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with the state register.
  always_comb begin
    ausgabeNext = '0;
    case (zustandNext)
      FETCH:      ausgabeNext[bLoadBefehl] = 1'b1;
      DECODE:     ausgabeNext[bDekodier] = 1'b1;
      ALU: begin
        ausgabeNext[bAluStart]   = 1'b1;
        ausgabeNext[bRegSchreib] = JALBefehl;
      end
      WB_JUMP:    ausgabeNext[bPc] = 1'b1;
      WB_STORE: begin
        ausgabeNext[bPc]         = 1'b1;
        ausgabeNext[bStoreDaten] = 1'b1;
      end
      WB_LOAD: begin
        ausgabeNext[bPc]        = 1'b1;
        ausgabeNext[bLoadDaten] = 1'b1;
      end
      WB_DEFAULT: begin
        ausgabeNext[bPc]         = 1'b1;
        ausgabeNext[bRegSchreib] = 1'b1;
      end
      INTERRUPT:  ausgabeNext[bInterrupt] = 1'b1;
      HALT:       ausgabeNext[bAngehalten] = 1'b1;
      FEHLER:     ausgabeNext[bBusFehler] = 1'b1;
      default:    ausgabeNext = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand         <= START;
      dekodierZaehler <= '0;
      warteZaehler    <= '0;
      ausgabe         <= '0;
    end else begin
      zustand <= zustandNext;
      ausgabe <= ausgabeNext;
      if (zustand == DECODE && zustandNext == DECODE) dekodierZaehler <= dekodierZaehler + 4'd1;
      else                                           dekodierZaehler <= '0;
      // Saturating wait count, restarted whenever a wait state is (re)entered
      if (zustandNext != zustand)                  warteZaehler <= '0;
      else if (wartet && warteZaehler != warteMax) warteZaehler <= warteZaehler + 1'b1;
    end
  end

  assign LoadBefehlSignal      = ausgabe[bLoadBefehl];
  assign DekodierSignal        = ausgabe[bDekodier];
  assign ALUStartSignal        = ausgabe[bAluStart];
  assign RegisterSchreibSignal = ausgabe[bRegSchreib];
  assign LoadDatenSignal       = ausgabe[bLoadDaten];
  assign StoreDatenSignal      = ausgabe[bStoreDaten];
  assign PCSignal              = ausgabe[bPc];
  assign InterruptSignal       = ausgabe[bInterrupt];
  assign Angehalten            = ausgabe[bAngehalten];
  assign BusFehler             = ausgabe[bBusFehler];

  assign PCSprungSignal = UnbedingterSprungBefehl || (BedingterSprungBefehl && Bedingung);

endmodule

// File: tb/tb_steuerung_generisch.sv
// Random instruction streams: each instruction is expanded into its expected per-cycle
// output trace plus the inputs to drive, then replayed against the controller.
module tb_steuerung_generisch;
  localparam int DZ = 3;
  localparam int TB = 4;
  localparam int TZ = 5;

  // Expected output vector: {LoadBefehl, Dekodier, ALUStart, RegSchreib, LoadDaten,
  //                          StoreDaten, PC, Interrupt, Angehalten, BusFehler}
  localparam logic [9:0] oNone   = 10'b00_0000_0000;
  localparam logic [9:0] oFetch  = 10'b10_0000_0000;
  localparam logic [9:0] oDec    = 10'b01_0000_0000;
  localparam logic [9:0] oAlu    = 10'b00_1000_0000;
  localparam logic [9:0] oRegW   = 10'b00_0100_0000;
  localparam logic [9:0] oLoadD  = 10'b00_0010_0000;
  localparam logic [9:0] oStoreD = 10'b00_0001_0000;
  localparam logic [9:0] oPc     = 10'b00_0000_1000;
  localparam logic [9:0] oInt    = 10'b00_0000_0100;
  localparam logic [9:0] oHalt   = 10'b00_0000_0010;
  localparam logic [9:0] oFehler = 10'b00_0000_0001;

  logic Clock, Reset;
  logic BefehlGeladen, ALUFertig, DatenGeladen, DatenGespeichert;
  logic LoadBefehl, StoreBefehl, JALBefehl, UnbedingterSprungBefehl, BedingterSprungBefehl;
  logic Bedingung, Interrupt, InterruptFreigabe, Halt;
  logic LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal;
  logic LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal;
  logic InterruptSignal, Angehalten, BusFehler;
  logic [9:0] ist;

  steuerung_generisch #(
    .DECODE_ZYKLEN(DZ), .TIMEOUT_BREITE(TB), .TIMEOUT_ZYKLEN(TZ)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .BefehlGeladen(BefehlGeladen), .ALUFertig(ALUFertig),
    .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
    .LoadBefehl(LoadBefehl), .StoreBefehl(StoreBefehl), .JALBefehl(JALBefehl),
    .UnbedingterSprungBefehl(UnbedingterSprungBefehl), .BedingterSprungBefehl(BedingterSprungBefehl),
    .Bedingung(Bedingung), .Interrupt(Interrupt), .InterruptFreigabe(InterruptFreigabe), .Halt(Halt),
    .LoadBefehlSignal(LoadBefehlSignal), .DekodierSignal(DekodierSignal),
    .ALUStartSignal(ALUStartSignal), .RegisterSchreibSignal(RegisterSchreibSignal),
    .LoadDatenSignal(LoadDatenSignal), .StoreDatenSignal(StoreDatenSignal),
    .PCSignal(PCSignal), .PCSprungSignal(PCSprungSignal),
    .InterruptSignal(InterruptSignal), .Angehalten(Angehalten), .BusFehler(BusFehler)
  );

  assign ist = {LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal,
                LoadDatenSignal, StoreDatenSignal, PCSignal, InterruptSignal, Angehalten, BusFehler};

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [9:0] soll;
    logic rst, bg, af, dg, ds, l, s, jal, u, b, irq, en, halt, bed;
  } zyklusT;

  zyklusT q[$];
  int pruefAnzahl = 0;
  int fehlerAnzahl = 0;
  logic aktL, aktS, aktJal, aktU, aktB;

  task automatic pruefe(input string tag, input logic [31:0] istWert, input logic [31:0] sollWert);
    pruefAnzahl++;
    if (istWert !== sollWert) begin
      fehlerAnzahl++;
      $display("FAIL %s: ist=%h soll=%h (t=%0t)", tag, istWert, sollWert, $time);
    end
  endtask

  // Append one cycle; inputs not relevant to that cycle get random values
  task automatic neu(input logic [9:0] soll);
    zyklusT z;
    z.soll = soll;  z.rst = 1'b0;
    z.bg   = 1'($urandom_range(0, 1));  z.af = 1'($urandom_range(0, 1));
    z.dg   = 1'($urandom_range(0, 1));  z.ds = 1'($urandom_range(0, 1));
    z.l = aktL;  z.s = aktS;  z.jal = aktJal;  z.u = aktU;  z.b = aktB;
    z.irq  = 1'($urandom_range(0, 1));  z.en = 1'($urandom_range(0, 1));
    z.halt = 1'($urandom_range(0, 1));  z.bed = 1'($urandom_range(0, 1));
    q.push_back(z);
  endtask

  task automatic setzeHs(input int idx, input int sel, input logic v);
    case (sel)
      0:       q[idx].bg = v;
      1:       q[idx].dg = v;
      default: q[idx].ds = v;
    endcase
  endtask

  task automatic keinIrq(input int idx);
    if (q[idx].irq) q[idx].en = 1'b0;
  endtask

  task automatic fehlerEnde();
    int k;
    k = $urandom_range(1, 4);
    for (int i = 0; i < k; i++) neu(oFehler);
    q[q.size()-1].rst = 1'b1;
    neu(oNone);
  endtask

  // Memory wait: handshake after d idle cycles; d >= TZ means it never comes in time
  task automatic warten(input logic [9:0] soll, input int sel, output bit fehler);
    int d;
    d = ($urandom_range(0, 9) == 0) ? TZ + $urandom_range(0, 3) : $urandom_range(0, TZ - 1);
    fehler = (d >= TZ);
    for (int i = 0; i < (fehler ? TZ : d + 1); i++) begin
      neu(soll);
      setzeHs(q.size() - 1, sel, !fehler && (i == d));
    end
    if (fehler) fehlerEnde();
  endtask

  task automatic grenze();
    int w, idx, h;
    w = $urandom_range(0, 9);
    idx = q.size() - 1;
    if (w < 2) begin
      q[idx].irq = 1'b1;  q[idx].en = 1'b1;
      neu(oInt);
    end else if (w < 4) begin
      keinIrq(idx);  q[idx].halt = 1'b1;
      h = $urandom_range(1, 10);
      for (int i = 0; i < h; i++) begin
        neu(oHalt);
        idx = q.size() - 1;
        if (i < h - 1) begin
          keinIrq(idx);  q[idx].halt = 1'b1;
        end else if ($urandom_range(0, 1) == 1) begin
          q[idx].irq = 1'b1;  q[idx].en = 1'b1;
          neu(oInt);
        end else begin
          keinIrq(idx);  q[idx].halt = 1'b0;
        end
      end
    end else begin
      keinIrq(idx);  q[idx].halt = 1'b0;
    end
  endtask

  task automatic baueBefehl();
    bit f;
    int da, cut;
    aktL   = ($urandom_range(0, 3) == 0);  aktS = ($urandom_range(0, 3) == 0);
    aktJal = ($urandom_range(0, 3) == 0);  aktU = ($urandom_range(0, 3) == 0);
    aktB   = ($urandom_range(0, 3) == 0);
    warten(oFetch, 0, f);
    if (f) return;
    for (int i = 0; i < DZ; i++) neu(oDec);
    da = $urandom_range(0, 5);
    for (int i = 0; i <= da; i++) begin
      neu(oAlu | (aktJal ? oRegW : oNone));
      q[q.size()-1].af = (i == da);
    end
    if (aktU || aktB) begin
      neu(oPc);
    end else if (aktS) begin
      warten(oPc | oStoreD, 2, f);
      if (f) return;
    end else if (aktL) begin
      warten(oPc | oLoadD, 1, f);
      if (f) return;
      neu(oPc | oRegW);
    end else begin
      neu(oPc | oRegW);
    end
    grenze();
    if ($urandom_range(0, 9) == 0) begin
      cut = $urandom_range(0, q.size() - 1);
      while (q.size() > cut + 1) q.delete(q.size() - 1);
      q[cut].rst = 1'b1;
      neu(oNone);
    end
  endtask

  task automatic spiele();
    for (int i = 0; i < q.size(); i++) begin
      @(posedge Clock);
      #1;
      pruefe("ausgaenge", 32'(ist), 32'(q[i].soll));
      Reset = q[i].rst;  BefehlGeladen = q[i].bg;  ALUFertig = q[i].af;
      DatenGeladen = q[i].dg;  DatenGespeichert = q[i].ds;
      LoadBefehl = q[i].l;  StoreBefehl = q[i].s;  JALBefehl = q[i].jal;
      UnbedingterSprungBefehl = q[i].u;  BedingterSprungBefehl = q[i].b;
      Interrupt = q[i].irq;  InterruptFreigabe = q[i].en;  Halt = q[i].halt;
      Bedingung = q[i].bed;
      #1;
      pruefe("pcSprung", 32'(PCSprungSignal), 32'(q[i].u | (q[i].b & q[i].bed)));
    end
    q.delete();
  endtask

  initial begin
    Clock = 1'b0;  Reset = 1'b1;
    BefehlGeladen = 1'b0;  ALUFertig = 1'b0;  DatenGeladen = 1'b0;  DatenGespeichert = 1'b0;
    LoadBefehl = 1'b0;  StoreBefehl = 1'b0;  JALBefehl = 1'b0;
    UnbedingterSprungBefehl = 1'b0;  BedingterSprungBefehl = 1'b0;
    Bedingung = 1'b0;  Interrupt = 1'b0;  InterruptFreigabe = 1'b0;  Halt = 1'b0;
    aktL = 1'b0;  aktS = 1'b0;  aktJal = 1'b0;  aktU = 1'b0;  aktB = 1'b0;
    neu(oNone);
    q[0].rst = 1'b1;
    neu(oNone);
    spiele();
    for (int n = 0; n < 300; n++) begin
      baueBefehl();
      $display("Befehl %0d: l=%0b s=%0b jal=%0b u=%0b b=%0b zyklen=%0d",
               n, aktL, aktS, aktJal, aktU, aktB, q.size());
      spiele();
    end
    $display("Simulation finished: %0d checks, %0d errors", pruefAnzahl, fehlerAnzahl);
    $finish;
  end
endmodule
